conv_punct: RTL and testbench
=============================

# conv_punct

Puncturing stage for the OFDM transmit path, directly downstream of the rate-1/2 convolutional encoder (g0 = 133, g1 = 171). It accepts one coded pair per handshake, deletes bits according to the packet's coding rate, and repacks the survivors into 2-bit output words for the interleaver. It supports valid/ready backpressure on both sides and flushes a residual bit at end of packet.

## Interface
- No parameters; widths are fixed by the coded-pair format.
- `clk`  in  1  transmit clock.
- `phy_tx_arestn`  in  1  asynchronous, active-low reset.
- `rate`  in  2  coding rate: 00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = 5/6 (see Configuration). Sampled only at packet start.
- `in_bits`  in  2  coded pair; [0] = A (g0 output), [1] = B (g1 output).
- `in_valid`  in  1  pair valid.
- `in_last`  in  1  marks the final pair of the packet.
- `in_ready`  out  1  pair accepted when `in_valid & in_ready`.
- `out_bits`  out  2  punctured word; [0] is the earlier bit in stream order.
- `out_valid`  out  1  word valid.
- `out_last`  out  1  final word of the packet.
- `out_pad`  out  1  `out_bits[1]` is a zero pad, not a coded bit. Only asserted with `out_last`.
- `out_ready`  in  1  downstream accepts the word when `out_valid & out_ready`.

## Operation
- States:
  - IDLE: no packet open.
  - RUN: packet open.
  - FLUSH: one residual word pending after last pair.
- Packet start is the first accepted pair in IDLE. That accept latches `rate` into `rate_q`, clears `phase` and holdover, and enters RUN. `rate` changes while in RUN are ignored.
- `phase` counts accepted pairs modulo the pattern period, then wraps to 0:
  - 1/2: period 1.
  - 2/3: period 2.
  - 3/4: period 3.
  - 5/6: period 5.
- Keep masks per phase, written {keepA,keepB}:
  - 1/2: {1,1}.
  - 2/3: {1,1},{1,0}.
  - 3/4: {1,1},{1,0},{0,1}.
  - 5/6: {1,1},{1,0},{0,1},{1,0},{0,1}.
- Every phase keeps at least one bit.
- Kept bits are taken in order A then B and appended after the holdover bit (0 or 1 bits) to form a total of 1–3 bits.
  - Total ≥ 2: the first two bits load the output register; any third bit becomes the holdover.
  - Total 1: the bit becomes the holdover and no word is produced.
- `in_ready = (state != FLUSH) & (!out_valid | out_ready)`. The output register can therefore always absorb a load on an accept cycle.
- On an accepted pair with `in_last`:
  - Total 2: load the word with `out_last = 1` → IDLE.
  - Total 3: load the first two bits (`out_last = 0`), keep the holdover → FLUSH.
  - Total 1: load {0, bit} with `out_last = 1`, `out_pad = 1` → IDLE.
- FLUSH: once the current word is taken (or the register is empty), load {0, holdover} with `out_last = 1`, `out_pad = 1` → IDLE. In FLUSH, `in_ready = 0`.
- `out_valid` clears on `out_ready` unless a new load happens in the same cycle. Load and drain in the same cycle are legal.
- `in_valid` without `in_last` in IDLE opens a packet. `in_last` on the first pair is legal (single-pair packet).

## Timing
- Reset values:
  - `state` = IDLE; `phase` = 0; holdover empty; `rate_q` = 00.
  - `out_bits` = 0, `out_valid` = 0, `out_last` = 0, `out_pad` = 0.
  - `in_ready` = 1.
- Reset is asynchronous and aborts any packet immediately, with no flush.
- Latency: a word formed on an accept cycle is valid on the next edge (1 cycle).
- Throughput:
  - 1/2: one word per accepted pair.
  - Other rates: input accepted every cycle with `out_ready` held high.
- The output register holds `out_bits`, `out_last` and `out_pad` stable while `out_valid & !out_ready`.

## Configuration
- `CONV_PUNCT_RATE_5_6_EN` defined: `rate` = 11 selects 5/6 (period 5, `phase` 3 bits).
- Not defined: `rate` = 11 is treated as 1/2, the 5/6 mask entries are removed, and the `phase` counter wraps at 3 (2 bits).

## Structure
- Shared package `conv_punct_pkg`:
  - Rate enum (R12, R23, R34, R56).
  - Period constants.
  - Keep-mask constant arrays.
- Sub-module `punct_mask`: combinational (`rate_q`, `phase`) → {keepA, keepB}, and next-phase wrap. The top level holds the FSM, holdover and output register.

## Test plan
- Rate 3/4, `out_ready` = 1; pairs 01, 11, 10 (`in_last` on the third) → words 01 then 11, second with `out_last` = 1, `out_pad` = 0; `in_ready` never drops.
- Rate 2/3; pairs 11, 01, 11 (last) → words 11, then {1 from pair 1 A, 1 from pair 2 A} = 11, then a FLUSH word {pad 0, 1} = 01 with `out_last` = 1, `out_pad` = 1; `in_ready` = 0 during FLUSH.
- Rate 1/2; 8 random pairs, `out_ready` toggling 1/0 each cycle → output equals input pair-for-pair, no loss or duplication, words stable while stalled.
- Change `rate` from 10 to 00 mid-packet → the remaining pairs are still punctured at 3/4. The next packet (after `out_last`) uses 1/2.
- Assert `phy_tx_arestn` = 0 during FLUSH with `out_valid` = 1 → all outputs drop to reset values asynchronously. The next packet starts at `phase` 0 with an empty holdover.
- With `CONV_PUNCT_RATE_5_6_EN`, rate 11, pairs 11, 11, 11, 11, 11 (last) → 3 words of 11, the last with `out_last` = 1. Without the macro, the same stimulus gives 5 words of 11.

Source files
------------

// File: rtl/conv_punct_pkg.sv
// rtl/conv_punct_pkg.sv - shared types, period constants and keep masks for conv_punct (optional 5/6 rate: CONV_PUNCT_RATE_5_6_EN)
package conv_punct_pkg;

`ifdef CONV_PUNCT_RATE_5_6_EN
    localparam int PHASE_W = 3;
`else
    localparam int PHASE_W = 2;
`endif
    localparam int NPH = 1 << PHASE_W;

    typedef enum logic [1:0] {
        R12 = 2'b00,
        R23 = 2'b01,
        R34 = 2'b10,
        R56 = 2'b11
    } rate_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    localparam int PERIOD_R12 = 1;
    localparam int PERIOD_R23 = 2;
    localparam int PERIOD_R34 = 3;

    // Entries are {keepA, keepB}, indexed by phase; slots past the period are never used.
    localparam logic [NPH-1:0][1:0] KEEP_R12 = '1;
`ifdef CONV_PUNCT_RATE_5_6_EN
    localparam int PERIOD_R56 = 5;
    localparam logic [NPH-1:0][1:0] KEEP_R23 = {{6{2'b11}}, 2'b10, 2'b11};
    localparam logic [NPH-1:0][1:0] KEEP_R34 = {{5{2'b11}}, 2'b01, 2'b10, 2'b11};
    localparam logic [NPH-1:0][1:0] KEEP_R56 = {{3{2'b11}}, 2'b01, 2'b10, 2'b01, 2'b10, 2'b11};
`else
    localparam logic [NPH-1:0][1:0] KEEP_R23 = {2'b11, 2'b11, 2'b10, 2'b11};
    localparam logic [NPH-1:0][1:0] KEEP_R34 = {2'b11, 2'b01, 2'b10, 2'b11};
`endif

endpackage

// File: rtl/punct_mask.sv
// rtl/punct_mask.sv - combinational keep-mask lookup and phase wrap for conv_punct
module punct_mask
    import conv_punct_pkg::*;
(
    input  logic [1:0]         rate_q,
    input  logic [PHASE_W-1:0] phase,
    output logic [1:0]         keep,
    output logic [PHASE_W-1:0] phase_nxt
);

    logic [PHASE_W-1:0] last_phase;

    always_comb begin
        keep       = KEEP_R12[phase];
        last_phase = PHASE_W'(PERIOD_R12 - 1);
        case (rate_e'(rate_q))
            R23: begin
                keep       = KEEP_R23[phase];
                last_phase = PHASE_W'(PERIOD_R23 - 1);
            end
            R34: begin
                keep       = KEEP_R34[phase];
                last_phase = PHASE_W'(PERIOD_R34 - 1);
            end
`ifdef CONV_PUNCT_RATE_5_6_EN
            R56: begin
                keep       = KEEP_R56[phase];
                last_phase = PHASE_W'(PERIOD_R56 - 1);
            end
`endif
            default: begin
                keep       = KEEP_R12[phase];
                last_phase = PHASE_W'(PERIOD_R12 - 1);
            end
        endcase
    end

    assign phase_nxt = (phase == last_phase) ? '0 : phase + 1'b1;

endmodule

// File: rtl/conv_punct.sv
// rtl/conv_punct.sv - puncturing stage with holdover repacking into 2-bit words (optional 5/6 rate: CONV_PUNCT_RATE_5_6_EN)
module conv_punct
    import conv_punct_pkg::*;
(
    input  logic       clk,
    input  logic       phy_tx_arestn,
    input  logic [1:0] rate,
    input  logic [1:0] in_bits,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [1:0] out_bits,
    output logic       out_valid,
    output logic       out_last,
    output logic       out_pad,
    input  logic       out_ready
);

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d, eff_phase, phase_nxt;
    logic [1:0]         rate_q, rate_d, eff_rate, keep;
    logic               hold_v_q, hold_v_d, hold_b_q, hold_b_d;
    logic [1:0]         out_bits_q, out_bits_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               out_pad_q, out_pad_d;
    logic               accept;
    logic [2:0]         seq;
    logic [1:0]         n;

    assign in_ready  = (state_q != S_FLUSH) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    // A packet-opening pair is punctured with the live rate at phase 0.
    assign eff_rate  = (state_q == S_IDLE) ? rate : rate_q;
    assign eff_phase = (state_q == S_IDLE) ? '0 : phase_q;

    punct_mask u_mask (
        .rate_q    (eff_rate),
        .phase     (eff_phase),
        .keep      (keep),
        .phase_nxt (phase_nxt)
    );

    // Survivors in stream order: holdover, then A, then B.
    always_comb begin
        seq = '0;
        n   = '0;
        if (hold_v_q) begin
            seq[n] = hold_b_q;
            n      = n + 2'd1;
        end
        if (keep[1]) begin
            seq[n] = in_bits[0];
            n      = n + 2'd1;
        end
        if (keep[0]) begin
            seq[n] = in_bits[1];
            n      = n + 2'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        rate_d      = rate_q;
        hold_v_d    = hold_v_q;
        hold_b_d    = hold_b_q;
        out_bits_d  = out_bits_q;
        out_valid_d = out_valid_q && !out_ready;
        out_last_d  = out_last_q;
        out_pad_d   = out_pad_q;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (accept) begin
                    rate_d  = eff_rate;
                    phase_d = phase_nxt;
                    state_d = in_last ? S_IDLE : S_RUN;
                    if (n == 2'd1) begin
                        if (in_last) begin
                            out_bits_d  = {1'b0, seq[0]};
                            out_valid_d = 1'b1;
                            out_last_d  = 1'b1;
                            out_pad_d   = 1'b1;
                            hold_v_d    = 1'b0;
                        end else begin
                            hold_v_d = 1'b1;
                            hold_b_d = seq[0];
                        end
                    end else begin
                        out_bits_d  = seq[1:0];
                        out_valid_d = 1'b1;
                        out_pad_d   = 1'b0;
                        out_last_d  = in_last && (n == 2'd2);
                        hold_v_d    = (n == 2'd3);
                        hold_b_d    = seq[2];
                        if (in_last && (n == 2'd3)) begin
                            state_d = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (!out_valid_q || out_ready) begin
                    out_bits_d  = {1'b0, hold_b_q};
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    out_pad_d   = 1'b1;
                    hold_v_d    = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge phy_tx_arestn) begin
        if (!phy_tx_arestn) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            rate_q      <= 2'b00;
            hold_v_q    <= 1'b0;
            hold_b_q    <= 1'b0;
            out_bits_q  <= 2'b00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_pad_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            rate_q      <= rate_d;
            hold_v_q    <= hold_v_d;
            hold_b_q    <= hold_b_d;
            out_bits_q  <= out_bits_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_pad_q   <= out_pad_d;
        end
    end

    assign out_bits  = out_bits_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_pad   = out_pad_q;

endmodule

// File: tb/tb_conv_punct.sv
// tb/tb_conv_punct.sv - self-checking bench for conv_punct against a bit-queue reference model
module tb_conv_punct;

    logic       clk = 1'b0;
    logic       phy_tx_arestn;
    logic [1:0] rate;
    logic [1:0] in_bits;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [1:0] out_bits;
    logic       out_valid;
    logic       out_last;
    logic       out_pad;
    logic       out_ready;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [1:0] bits;
        logic       last;
        logic       pad;
    } word_t;

    word_t      expq[$];
    logic [1:0] pairs[$];
    logic       flush_exp;

    always #5 clk = ~clk;

    conv_punct dut (
        .clk           (clk),
        .phy_tx_arestn (phy_tx_arestn),
        .rate          (rate),
        .in_bits       (in_bits),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .out_bits      (out_bits),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_pad       (out_pad),
        .out_ready     (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {keepA,keepB} for pair index i of a packet at rate r.
    function automatic logic [1:0] keep_of(input logic [1:0] r, input int i);
        case (r)
            2'b01: return (i % 2 == 0) ? 2'b11 : 2'b10;
            2'b10: begin
                if (i % 3 == 0) return 2'b11;
                else if (i % 3 == 1) return 2'b10;
                else return 2'b01;
            end
`ifdef CONV_PUNCT_RATE_5_6_EN
            2'b11: begin
                if (i % 5 == 0) return 2'b11;
                else if (i % 5 == 1 || i % 5 == 3) return 2'b10;
                else return 2'b01;
            end
`endif
            default: return 2'b11;
        endcase
    endfunction

    task automatic build_model(input logic [1:0] r);
        logic       bq[$];
        int         before_last;
        logic [1:0] k;
        logic [1:0] last_keep;
        word_t      w;
        expq.delete();
        before_last = 0;
        last_keep   = 2'b00;
        for (int i = 0; i < pairs.size(); i++) begin
            k = keep_of(r, i);
            if (i == pairs.size() - 1) begin
                before_last = bq.size();
                last_keep   = k;
            end
            if (k[1]) bq.push_back(pairs[i][0]);
            if (k[0]) bq.push_back(pairs[i][1]);
        end
        while (bq.size() > 0) begin
            w.bits[0] = bq.pop_front();
            if (bq.size() > 0) begin
                w.bits[1] = bq.pop_front();
                w.pad     = 1'b0;
            end else begin
                w.bits[1] = 1'b0;
                w.pad     = 1'b1;
            end
            w.last = (bq.size() == 0);
            expq.push_back(w);
        end
        flush_exp = (before_last % 2 == 1) && (last_keep == 2'b11);
    endtask

    // mode 0: out_ready high; 1: toggling; 2: random ready and random input gaps
    task automatic run_packet(input logic [1:0] r, input int mode, input logic [1:0] mid_rate,
                              input string tag);
        int    sent = 0;
        int    cyc = 0;
        bit    stalled = 0;
        bit    after_last = 0;
        word_t held = '0;
        word_t w;
        build_model(r);
        while ((sent < pairs.size() || expq.size() > 0) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            rate     = (sent == 0) ? r : mid_rate;
            in_valid = (sent < pairs.size()) && (mode != 2 || $urandom_range(0, 3) != 0);
            in_bits  = in_valid ? pairs[sent] : 2'b00;
            in_last  = in_valid && (sent == pairs.size() - 1);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = cyc[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (stalled) check({tag, " stable"}, {out_valid, out_bits, out_last, out_pad}, {1'b1, held});
            if (after_last && out_ready) check({tag, " in_ready after last"}, in_ready, !flush_exp);
            after_last = 0;
            if (mode == 0 && in_valid) check({tag, " in_ready"}, in_ready, 1);
            if (out_valid && out_ready) begin
                check({tag, " word expected"}, expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    w = expq.pop_front();
                    check({tag, " word"}, {out_bits, out_last, out_pad}, w);
                end
            end
            stalled = out_valid && !out_ready;
            held    = {out_bits, out_last, out_pad};
            if (in_valid && in_ready) begin
                sent++;
                if (in_last) after_last = 1;
            end
        end
        check({tag, " drained"}, {sent == pairs.size(), expq.size() == 0}, 2'b11);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic rand_pairs(input int n);
        pairs.delete();
        for (int i = 0; i < n; i++) pairs.push_back(2'($urandom_range(0, 3)));
    endtask

    initial begin
        phy_tx_arestn = 1'b0;
        rate          = 2'b00;
        in_bits       = 2'b00;
        in_valid      = 1'b0;
        in_last       = 1'b0;
        out_ready     = 1'b0;
        #1;
        check("reset outputs", {out_valid, out_bits, out_last, out_pad, in_ready}, 6'b000001);
        repeat (2) @(negedge clk);
        phy_tx_arestn = 1'b1;

        pairs = '{2'b01, 2'b11, 2'b10};
        run_packet(2'b10, 0, 2'b10, "r34 directed");

        pairs = '{2'b11, 2'b01, 2'b11};
        run_packet(2'b01, 0, 2'b01, "r23 directed");

        rand_pairs(8);
        run_packet(2'b00, 1, 2'b00, "r12 toggle");

        rand_pairs(7);
        run_packet(2'b10, 0, 2'b00, "rate change");
        rand_pairs(4);
        run_packet(2'b00, 0, 2'b00, "after change");

        // Abort a packet while a word is stalled in FLUSH.
        pairs     = '{2'b11, 2'b01, 2'b11};
        rate      = 2'b01;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bits  = pairs[i];
            in_last  = (i == 2);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        check("flush in_ready", in_ready, 0);
        check("flush out_valid", out_valid, 1);
        #2 phy_tx_arestn = 1'b0;
        #1;
        check("async reset", {out_valid, out_bits, out_last, out_pad, in_ready}, 6'b000001);
        @(negedge clk);
        phy_tx_arestn = 1'b1;
        rand_pairs(6);
        run_packet(2'b10, 0, 2'b10, "post reset");

        pairs = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
        run_packet(2'b11, 0, 2'b11, "rate 11");

        for (int p = 0; p < 24; p++) begin
            rand_pairs($urandom_range(1, 12));
            run_packet(2'($urandom_range(0, 3)), 2, 2'($urandom_range(0, 3)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
